// File: rtl/fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe -- pipelined floating-point multiplier, {sign, exp, frac} format.
//
// The product is formed combinationally from the operands and then carried
// through STAGES pipeline registers, so a pair accepted in cycle N is presented
// in cycle N+STAGES. Subnormal inputs are flushed to zero and rounding is
// truncation toward zero.
//
// Handshake (valid/ready): a pair is taken when in_valid && in_ready, and a
// result leaves when out_valid && out_ready. The pipeline advances as a whole
// when the output register is empty or being drained (adv); otherwise every
// stage holds, so a stalled out_data stays stable until it retires. Bubbles
// move with the data and are not squeezed out.
//
// Parameters:
//   EXP_W   exponent field width (4..11)
//   MAN_W   stored fraction width (4..52)
//   STAGES  pipeline latency in cycles (1..6)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   in_valid   operand pair present on in_a / in_b
//   in_ready   block accepts the pair this cycle
//   in_a/in_b  operands, {sign, exp, frac}
//   out_valid  out_data holds a result
//   out_ready  downstream takes the result this cycle
//   out_data   product, same layout as operands
//   out_flags  {invalid, overflow, underflow, inexact}; only when the macro
//              FP_MUL_FLAGS_EN is defined
// -----------------------------------------------------------------------------
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]             out_flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;   // full product width
  localparam int EW = EXP_W + 2;       // signed exponent working width

  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0]         QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Operand fields and classification
  // ---------------------------------------------------------------------------
  logic             sa, sb, sign_x;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa = in_a[W-1];
  assign sb = in_b[W-1];
  assign ea = in_a[MAN_W +: EXP_W];
  assign eb = in_b[MAN_W +: EXP_W];
  assign fa = in_a[MAN_W-1:0];
  assign fb = in_b[MAN_W-1:0];
  assign sign_x = sa ^ sb;

  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  logic is_invalid, any_inf, any_zero, special;
  assign is_invalid = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  assign any_inf    = a_inf || b_inf;
  assign any_zero   = a_zero || b_zero;
  assign special    = is_invalid || any_inf || any_zero;

  // ---------------------------------------------------------------------------
  // Significand product, normalisation and exponent
  // ---------------------------------------------------------------------------
  logic [PW-1:0]          prod, p_norm;
  logic signed [EW-1:0]   e_raw, e_norm;
  logic [MAN_W-1:0]       frac_t;
  logic                   ovf, udf;

  assign prod  = PW'({1'b1, fa}) * PW'({1'b1, fb});
  assign e_raw = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  // Product lies in [1,4): when the top bit is set the value is >= 2 and the
  // exponent moves up by one. Shifting the other case left by one lines both
  // up so the kept fraction is always just below the top bit.
  assign p_norm = prod[PW-1] ? prod : (prod << 1);
  assign e_norm = e_raw + EW'(prod[PW-1]);
  assign frac_t = p_norm[PW-2 -: MAN_W];

  assign ovf = !special && (e_norm >= E_MAX);
  assign udf = !special && (e_norm[EW-1] || (e_norm == '0));

  logic [W-1:0] result_d;

  always_comb begin
    result_d = {sign_x, e_norm[EXP_W-1:0], frac_t};
    if (is_invalid) begin
      result_d = QNAN;
    end else if (any_inf || ovf) begin
      result_d = {sign_x, EXP_ONES, {MAN_W{1'b0}}};
    end else if (any_zero || udf) begin
      result_d = {sign_x, {(W-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline: all stages shift together on adv, otherwise hold.
  // ---------------------------------------------------------------------------
  logic             adv;
  logic [W-1:0]     data_q  [STAGES];
  logic             valid_q [STAGES];

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else if (adv) begin
      valid_q[0] <= in_valid && in_ready;
      data_q[0]  <= result_d;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

`ifdef FP_MUL_FLAGS_EN
  // ---------------------------------------------------------------------------
  // Exception flags, carried alongside the data so they stay aligned.
  // ---------------------------------------------------------------------------
  logic       lost;
  logic [3:0] flags_d;
  logic [3:0] flags_q [STAGES];
  logic       unused_bits;

  assign lost        = |p_norm[MAN_W:0];
  assign unused_bits = p_norm[PW-1];
  assign flags_d     = {is_invalid, ovf, udf, ovf || udf || (!special && lost)};
  assign out_flags   = flags_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        flags_q[i] <= '0;
      end
    end else if (adv) begin
      flags_q[0] <= flags_d;
      for (int i = 1; i < STAGES; i++) begin
        flags_q[i] <= flags_q[i-1];
      end
    end
  end
`else
  // Discarded product bits only feed the inexact flag.
  logic unused_bits;
  assign unused_bits = ^{p_norm[PW-1], p_norm[MAN_W:0]};
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_pipe -- self-checking bench for fp_mul_pipe.
// Two instances: default single precision (STAGES=3) and a half-precision
// build with STAGES=1. Expected results come from directed constants and from
// an integer-arithmetic reference model of the multiply rules.
// -----------------------------------------------------------------------------
module tb_fp_mul_pipe;
  localparam int STAGES = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;

  logic        h_in_valid = 1'b0;
  logic        h_out_ready = 1'b1;
  logic [15:0] h_in_a = '0;
  logic [15:0] h_in_b = '0;
  logic        h_in_ready, h_out_valid;
  logic [15:0] h_out_data;

`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  out_flags, h_out_flags;
  logic [3:0]  flg_q[$];
`endif

  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  bit          rnd_done = 1'b0;

  // ---------------------------------------------------------------------------
  // Clock / DUTs
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES)) dut (
`ifdef FP_MUL_FLAGS_EN
    .out_flags (out_flags),
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .STAGES(1)) dut_h (
`ifdef FP_MUL_FLAGS_EN
    .out_flags (h_out_flags),
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .in_a      (h_in_a),
    .in_b      (h_in_b),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .out_data  (h_out_data)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: returns {flags[3:0], result[63:0]}
  // ---------------------------------------------------------------------------
  function automatic logic [67:0] ref_mul(input int ew, input int mw,
                                          input longint unsigned a,
                                          input longint unsigned b);
    longint unsigned one = 1;
    longint unsigned emax, bias, fmask, ea, eb, fa, fb, s, prod, frac, res, inf_v;
    longint          e;
    int              sh;
    logic [3:0]      fl;
    fl    = 4'b0000;
    emax  = (one << ew) - 1;
    bias  = (one << (ew - 1)) - 1;
    fmask = (one << mw) - 1;
    s     = ((a >> (ew + mw)) ^ (b >> (ew + mw))) & one;
    ea    = (a >> mw) & emax;
    eb    = (b >> mw) & emax;
    fa    = a & fmask;
    fb    = b & fmask;
    inf_v = (s << (ew + mw)) | (emax << mw);
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0) ||
        (ea == emax && eb == 0) || (eb == emax && ea == 0)) begin
      res = (emax << mw) | (one << (mw - 1));
      fl  = 4'b1000;
    end else if (ea == emax || eb == emax) begin
      res = inf_v;
    end else if (ea == 0 || eb == 0) begin
      res = s << (ew + mw);
    end else begin
      prod = (fa | (one << mw)) * (fb | (one << mw));
      e    = longint'(ea) + longint'(eb) - longint'(bias);
      if (prod >= (one << (2 * mw + 1))) begin
        e++;
        sh = mw + 1;
      end else begin
        sh = mw;
      end
      frac = (prod >> sh) - (one << mw);
      if (e >= longint'(emax)) begin
        res = inf_v;
        fl  = 4'b0110;
      end else if (e <= 0) begin
        res = s << (ew + mw);
        fl  = 4'b0011;
      end else begin
        res = (s << (ew + mw)) | ($unsigned(e) << mw) | frac;
        fl  = {3'b000, ((prod & ((one << sh) - 1)) != 0)};
      end
    end
    return {fl, res[63:0]};
  endfunction

  // Random operand with a mix of zeros, subnormals, infinities, NaNs,
  // near-unity exponents and full-range exponents.
  function automatic logic [63:0] rand_op(input int ew, input int mw);
    longint unsigned one = 1;
    longint unsigned emax, bias, e, f, s;
    int r;
    r    = $urandom_range(0, 15);
    emax = (one << ew) - 1;
    bias = (one << (ew - 1)) - 1;
    s    = longint'($urandom_range(0, 1));
    f    = {$urandom, $urandom};
    f    = f & ((one << mw) - 1);
    if (r == 0) begin
      e = 0;
    end else if (r == 1) begin
      e = emax;
      f = 0;
    end else if (r == 2) begin
      e = emax;
      if (f == 0) f = 1;
    end else if (r < 10) begin
      e = bias + longint'($urandom_range(0, 8)) - 4;
    end else begin
      e = longint'($urandom_range(1, 32'(emax) - 1));
    end
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  // Driver: hold a pair until accepted, then record its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    logic [67:0] r;
    bit          acc;
    int          guard;
    guard    = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 500);
    in_valid = 1'b0;
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_accept: in_ready stayed %0b, required 1 within 500 cycles", in_ready);
    end else begin
      r = ref_mul(8, 23, {32'h0, a}, {32'h0, b});
      exp_q.push_back(r[31:0]);
`ifdef FP_MUL_FLAGS_EN
      flg_q.push_back(r[67:64]);
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid);
    end
    n_tests++;
    if (out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h required 00000000", out_data);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
`ifdef FP_MUL_FLAGS_EN
    n_tests++;
    if (out_flags !== 4'b0) begin
      n_fail++; $display("FAIL reset_out_flags: got %b required 0000", out_flags);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] va [8] = '{32'h40000000, 32'hBFC00000, 32'h3F800001, 32'h7F800000,
                            32'hFF800000, 32'h80000000, 32'h7F000000, 32'h00800000};
    logic [31:0] vb [8] = '{32'h40400000, 32'h40000000, 32'h3F800001, 32'h00000000,
                            32'h40000000, 32'h3F800000, 32'h7F000000, 32'h3F000000};
    logic [31:0] vr [8] = '{32'h40C00000, 32'hC0400000, 32'h3F800002, 32'h7FC00000,
                            32'hFF800000, 32'h80000000, 32'h7F800000, 32'h00000000};
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  vf [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b1000,
                            4'b0000, 4'b0000, 4'b0110, 4'b0011};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a     = va[i];
      in_b     = vb[i];
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
        @(negedge clk);
        if (k == STAGES - 1) begin
          n_tests++;
          if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL dir%0d_early: out_valid %0b at cycle %0d, required 0", i, out_valid, k);
          end
        end
        if (k == STAGES) begin
          n_tests++;
          if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL dir%0d_latency: out_valid %0b at cycle %0d, required 1", i, out_valid, k);
          end
          n_tests++;
          if (out_data !== vr[i]) begin
            n_fail++; $display("FAIL dir%0d_data: got %h required %h", i, out_data, vr[i]);
          end
`ifdef FP_MUL_FLAGS_EN
          n_tests++;
          if (out_flags !== vf[i]) begin
            n_fail++; $display("FAIL dir%0d_flags: got %b required %b", i, out_flags, vf[i]);
          end
`endif
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ra, rb;
    exp_q.delete();
`ifdef FP_MUL_FLAGS_EN
    flg_q.delete();
`endif
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          ra = rand_op(8, 23);
          rb = rand_op(8, 23);
          send(ra[31:0], rb[31:0]);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        int          got, cyc;
        logic [31:0] prev, e;
        bit          stalled;
        got = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while (got < 10 && cyc < 300) begin
          @(negedge clk);
          cyc++;
          if (stalled) begin
            n_tests++;
            if (out_data !== prev || out_valid !== 1'b1) begin
              n_fail++; $display("FAIL b2b_stall_stable: got %h/%0b required %h/1", out_data, out_valid, prev);
            end
          end
          if (out_valid && out_ready) begin
            got++;
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL b2b_extra: got result %h, required none", out_data);
            end else begin
              e = exp_q.pop_front();
              if (out_data !== e) begin
                n_fail++; $display("FAIL b2b_data: got %h required %h", out_data, e);
              end
`ifdef FP_MUL_FLAGS_EN
              n_tests++;
              if (out_flags !== flg_q[0]) begin
                n_fail++; $display("FAIL b2b_flags: got %b required %b", out_flags, flg_q[0]);
              end
              void'(flg_q.pop_front());
`endif
            end
          end
          stalled = out_valid && !out_ready;
          prev    = out_data;
        end
        n_tests++;
        if (got != 10) begin
          n_fail++; $display("FAIL b2b_count: got %0d results required 10", got);
        end
      end
    join
    for (int i = 0; i < STAGES + 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_duplicate: out_valid %0b after stream, required 0", out_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    localparam int N = 150;
    logic [63:0] ra, rb;
    exp_q.delete();
`ifdef FP_MUL_FLAGS_EN
    flg_q.delete();
`endif
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          ra = rand_op(8, 23);
          rb = rand_op(8, 23);
          send(ra[31:0], rb[31:0]);
        end
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        int          got, cyc;
        logic [31:0] prev, e;
        bit          stalled;
        got = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while (got < N && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          if (stalled) begin
            n_tests++;
            if (out_data !== prev || out_valid !== 1'b1) begin
              n_fail++; $display("FAIL rnd_stall_stable: got %h/%0b required %h/1", out_data, out_valid, prev);
            end
          end
          if (out_valid && out_ready) begin
            got++;
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rnd_extra: got result %h, required none", out_data);
            end else begin
              e = exp_q.pop_front();
              if (out_data !== e) begin
                n_fail++; $display("FAIL rnd_data: got %h required %h", out_data, e);
              end
`ifdef FP_MUL_FLAGS_EN
              n_tests++;
              if (out_flags !== flg_q[0]) begin
                n_fail++; $display("FAIL rnd_flags: got %b required %b", out_flags, flg_q[0]);
              end
              void'(flg_q.pop_front());
`endif
            end
          end
          stalled = out_valid && !out_ready;
          prev    = out_data;
        end
        n_tests++;
        if (got != N) begin
          n_fail++; $display("FAIL rnd_count: got %0d results required %0d", got, N);
        end
        rnd_done = 1'b1;
      end
    join
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'h40000000;
    in_b      = 32'h40400000;
    @(posedge clk);
    #1;
    in_a = 32'h3F800000;
    in_b = 32'h40000000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL inflight_in_ready: got %0b required 0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL inflight_out_valid: got %0b required 0", out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL inflight_retired: out_valid %0b data %h, required 0", out_valid, out_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_half();
    logic [63:0] ra, rb;
    logic [67:0] r;
    h_out_ready = 1'b1;
    for (int i = 0; i < 41; i++) begin
      if (i == 0) begin
        ra = 64'h4000;
        rb = 64'h4200;
      end else begin
        ra = rand_op(5, 10);
        rb = rand_op(5, 10);
      end
      r          = ref_mul(5, 10, ra, rb);
      h_in_valid = 1'b1;
      h_in_a     = ra[15:0];
      h_in_b     = rb[15:0];
      @(posedge clk);
      #1 h_in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (h_out_valid !== 1'b1) begin
        n_fail++; $display("FAIL half%0d_latency: out_valid %0b required 1", i, h_out_valid);
      end
      n_tests++;
      if (i == 0 && h_out_data !== 16'h4600) begin
        n_fail++; $display("FAIL half_directed: got %h required 4600", h_out_data);
      end else if (h_out_data !== r[15:0]) begin
        n_fail++; $display("FAIL half%0d_data: %h x %h got %h required %h", i, ra[15:0], rb[15:0], h_out_data, r[15:0]);
      end
`ifdef FP_MUL_FLAGS_EN
      n_tests++;
      if (h_out_flags !== r[67:64]) begin
        n_fail++; $display("FAIL half%0d_flags: got %b required %b", i, h_out_flags, r[67:64]);
      end
`endif
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    test_half();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports named as below.
REQ-002 EXP_W, 8, exponent field width in bits (legal range 4..11).
REQ-003 MAN_W, 23, stored fraction width in bits (legal range 4..52).
REQ-004 STAGES, 3, pipeline latency in cycles (legal range 1..6).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous reset, active high.
REQ-007 in_valid  input  1  operand pair is present on in_a and in_b.
REQ-008 in_ready  output  1  the block accepts the operand pair this cycle.
REQ-009 in_a  input  1+EXP_W+MAN_W  operand A, laid out {sign, exp, frac}.
REQ-010 in_b  input  1+EXP_W+MAN_W  operand B, same layout as in_a.
REQ-011 out_valid  output  1  out_data holds a result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 out_data  output  1+EXP_W+MAN_W  product, same layout as the operands.
REQ-014 out_flags  output  4  {invalid, overflow, underflow, inexact}; present only when FP_MUL_FLAGS_EN is defined.

Function
REQ-015 A transfer occurs when in_valid && in_ready; a result retires when out_valid && out_ready.
REQ-016 The pipeline advances when adv = !out_valid || out_ready; the block SHALL drive in_ready = adv && !rst.
REQ-017 When the pipeline stalls, every stage SHALL hold; a stalled out_data SHALL remain stable until it retires.
REQ-018 With adv held high, the result of a transfer accepted in cycle N SHALL be on out_valid/out_data in cycle N+STAGES.
REQ-019 The block SHALL sustain one result per cycle; results SHALL retire in acceptance order; bubbles travel through and are not compressed.
REQ-020 BIAS is 2^(EXP_W-1)-1; the result sign is sA XOR sB in every case, including zero, infinity and overflow; NaN is the exception.
REQ-021 Classification: exp=0 is zero (subnormal inputs are flushed to zero); exp all-ones with frac=0 is infinity; exp all-ones with frac!=0 is NaN.
REQ-022 Priority 1: a NaN operand, or infinity times zero, SHALL produce the canonical NaN {0, all-ones, 1 followed by zeros} and set invalid.
REQ-023 Priority 2: an infinity operand SHALL produce infinity with the XOR sign.
REQ-024 Priority 3: a zero operand SHALL produce zero with the XOR sign.
REQ-025 Otherwise the product P = {1,fA} x {1,fB} SHALL be formed at full width (2*MAN_W+2 bits).
REQ-026 The biased exponent SHALL be computed as E = eA + eB - BIAS, in signed arithmetic of width EXP_W+2.
REQ-027 If the MSB of P is set, E SHALL increment and the fraction SHALL be taken from the bits just below the MSB; otherwise the fraction SHALL be taken from the bits below the next bit.
REQ-028 Rounding SHALL be truncation toward zero; inexact SHALL be set when any discarded product bit is 1.
REQ-029 If E >= 2^EXP_W-1, the result SHALL be infinity and overflow and inexact SHALL be set.
REQ-030 If E <= 0, the result SHALL be zero and underflow and inexact SHALL be set.

Reset
REQ-031 While rst is high at a clock edge, all stage valid bits and out_valid SHALL clear, and out_data and out_flags SHALL be set to 0.
REQ-032 Operations in flight when reset is asserted SHALL be discarded with no retirement.
REQ-033 in_ready SHALL be 0 during reset; the first transfer can occur in the cycle after rst deasserts.

Configuration
REQ-034 With FP_MUL_FLAGS_EN defined, out_flags SHALL exist and be registered aligned with out_data.
REQ-035 With FP_MUL_FLAGS_EN undefined, the out_flags port and its logic SHALL be absent, and out_data SHALL be unchanged.

Verification
REQ-036 Default parameters, out_ready=1: 0x40000000 x 0x40400000 -> 0x40C00000 exactly 3 cycles after acceptance, flags 0000.
REQ-037 Sign and truncation: 0xBFC00000 x 0x40000000 -> 0xC0400000; 0x3F800001 x 0x3F800001 -> 0x3F800002 with inexact=1.
REQ-038 Special cases: 0x7F800000 x 0x00000000 -> 0x7FC00000 with invalid=1; 0xFF800000 x 0x40000000 -> 0xFF800000; 0x80000000 x 0x3F800000 -> 0x80000000.
REQ-039 Range: 0x7F000000 x 0x7F000000 -> 0x7F800000 with overflow=1; 0x00800000 x 0x3F000000 -> 0x00000000 with underflow=1.
REQ-040 Backpressure: stream 10 back-to-back pairs with out_ready low for 5 cycles mid-stream -> 10 results in order, none lost or duplicated, out_data stable while stalled.
REQ-041 Reset and parameters: assert rst with 2 operations in flight -> no retirement, out_valid=0 next cycle; with STAGES=1, EXP_W=5, MAN_W=10, the half-precision 0x4000 x 0x4200 -> 0x4600 after 1 cycle.
